// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive path (and later the transmitter).
// Holds the receiver state encoding, the baud-accumulator increment function
// and the mid-bit sample index helpers.
package rs232_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Fractional accumulator increment, rounded to nearest, in 64-bit arithmetic.
    function automatic int unsigned baud_inc(
        input longint unsigned clock_freq,
        input longint unsigned baud_rate,
        input longint unsigned oversample,
        input longint unsigned acc_width
    );
        longint unsigned num;
        num = ((baud_rate * oversample) << (acc_width - 64'd4)) + (clock_freq >> 5);
        return 32'(num / (clock_freq >> 4));
    endfunction

    // Three consecutive sample ticks centred on the middle of a bit.
    function automatic int unsigned mid_sample_lo(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int unsigned mid_sample(input int unsigned oversample);
        return oversample / 2;
    endfunction

    function automatic int unsigned mid_sample_hi(input int unsigned oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/rs232_baud_tick_gen.sv
// Fractional baud tick generator: one-cycle tick at BAUD_RATE*OVERSAMPLE on average.
// Ports: clock, reset_neg (async active-low), clear (sync), tick (carry of accumulator).
module rs232_baud_tick_gen
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned BAUD_ACC_WIDTH = 16
) (
    input  logic clock,
    input  logic reset_neg,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W   = BAUD_ACC_WIDTH;
    localparam int unsigned INC = baud_inc(64'(CLOCK_FREQ), 64'(BAUD_RATE),
                                           64'(OVERSAMPLE), 64'(BAUD_ACC_WIDTH));
    localparam logic [W:0] INC_W = (W+1)'(INC);

    logic [W:0] acc;

    // Carry bit is dropped every cycle and re-emerges as the tick.
    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[W-1:0]} + INC_W;
        end
    end

    assign tick = acc[W];

endmodule

// File: rtl/rs232_receiver.sv
// UART 8N1 receiver, LSB first, oversampled with 2-of-3 mid-bit majority vote.
// Ports: clock, reset_neg (async active-low), Present_Processing_Completed (sync clear),
//        rx_receiver (async serial in), rx_dataout (last good byte),
//        rx_dataout_ready / rx_framing_error (1-cycle strobes), rx_busy (frame in progress).
module rs232_receiver
    import rs232_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 100000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned BAUD_ACC_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset_neg,
    input  logic       Present_Processing_Completed,
    input  logic       rx_receiver,
    output logic [7:0] rx_dataout,
    output logic       rx_dataout_ready,
    output logic       rx_framing_error,
    output logic       rx_busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_LO = SW'(mid_sample_lo(OVERSAMPLE));
    localparam logic [SW-1:0] MID    = SW'(mid_sample(OVERSAMPLE));
    localparam logic [SW-1:0] MID_HI = SW'(mid_sample_hi(OVERSAMPLE));

    logic            tick;
    logic            rx_meta, rxs;
    rx_state_t       state, state_next;
    logic [SW-1:0]   scnt, scnt_next;
    logic            s0, s0_next, s1, s1_next;
    logic [7:0]      shift, shift_next;
    logic [2:0]      bidx, bidx_next;
    logic [7:0]      dout_next;
    logic            ready_next, ferr_next;
    logic            majority, decide;

    rs232_baud_tick_gen #(
        .CLOCK_FREQ     (CLOCK_FREQ),
        .BAUD_RATE      (BAUD_RATE),
        .OVERSAMPLE     (OVERSAMPLE),
        .BAUD_ACC_WIDTH (BAUD_ACC_WIDTH)
    ) u_tick (
        .clock     (clock),
        .reset_neg (reset_neg),
        .clear     (Present_Processing_Completed),
        .tick      (tick)
    );

    // Third vote is the live synchronized bit on the deciding tick.
    assign majority = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign decide   = tick && (scnt == MID_HI);

    // State register, synchronizer and registered outputs.
    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            rx_meta          <= 1'b1;
            rxs              <= 1'b1;
            state            <= IDLE;
            scnt             <= '0;
            s0               <= 1'b1;
            s1               <= 1'b1;
            shift            <= '0;
            bidx             <= '0;
            rx_dataout       <= 8'h00;
            rx_dataout_ready <= 1'b0;
            rx_framing_error <= 1'b0;
            rx_busy          <= 1'b0;
        end else if (Present_Processing_Completed) begin
            rx_meta          <= 1'b1;
            rxs              <= 1'b1;
            state            <= IDLE;
            scnt             <= '0;
            s0               <= 1'b1;
            s1               <= 1'b1;
            shift            <= '0;
            bidx             <= '0;
            rx_dataout       <= 8'h00;
            rx_dataout_ready <= 1'b0;
            rx_framing_error <= 1'b0;
            rx_busy          <= 1'b0;
        end else begin
            rx_meta          <= rx_receiver;
            rxs              <= rx_meta;
            state            <= state_next;
            scnt             <= scnt_next;
            s0               <= s0_next;
            s1               <= s1_next;
            shift            <= shift_next;
            bidx             <= bidx_next;
            rx_dataout       <= dout_next;
            rx_dataout_ready <= ready_next;
            rx_framing_error <= ferr_next;
            rx_busy          <= (state_next != IDLE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        scnt_next  = tick ? scnt + SW'(1) : scnt;
        s0_next    = (tick && scnt == MID_LO) ? rxs : s0;
        s1_next    = (tick && scnt == MID)    ? rxs : s1;
        shift_next = shift;
        bidx_next  = bidx;
        dout_next  = rx_dataout;
        ready_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                if (tick && !rxs) begin
                    state_next = START;
                    scnt_next  = '0;
                end
            end
            START: begin
                if (decide) begin
                    state_next = majority ? IDLE : DATA;
                    bidx_next  = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_next = {majority, shift[7:1]};
                    bidx_next  = bidx + 3'd1;
                    if (bidx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a following start edge is not missed.
                if (decide) begin
                    if (majority) begin
                        dout_next  = shift;
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (tick && rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rs232_receiver.sv
// Directed bench for rs232_receiver. The DUT runs from a 10 MHz clock so the
// line-level timing at 115200 baud stays short in clock cycles.
`timescale 1ns/1ps
module tb_rs232_receiver;

    localparam real CLK_HALF = 50.0;
    localparam real BIT_NS   = 1.0e9 / 115200.0;

    logic       clock = 1'b0;
    logic       reset_neg = 1'b0;
    logic       ppc = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_dataout;
    logic       rx_dataout_ready;
    logic       rx_framing_error;
    logic       rx_busy;

    int passed = 0;
    int total  = 0;

    int ready_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    int busy_cycles = 0;
    logic prev_ready = 1'b0;
    logic prev_ferr = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] last_good = 8'h00;

    rs232_receiver #(
        .CLOCK_FREQ     (10000000),
        .BAUD_RATE      (115200),
        .OVERSAMPLE     (16),
        .BAUD_ACC_WIDTH (16)
    ) dut (
        .clock                        (clock),
        .reset_neg                    (reset_neg),
        .Present_Processing_Completed (ppc),
        .rx_receiver                  (rx),
        .rx_dataout                   (rx_dataout),
        .rx_dataout_ready             (rx_dataout_ready),
        .rx_framing_error             (rx_framing_error),
        .rx_busy                      (rx_busy)
    );

    always #(CLK_HALF) clock = ~clock;

    // Strobe recorder, sampled mid-cycle.
    always @(negedge clock) begin
        if (rx_dataout_ready) begin
            ready_cnt++;
            got_q.push_back(rx_dataout);
        end
        if (rx_framing_error) ferr_cnt++;
        if (rx_dataout_ready && rx_framing_error) both_cnt++;
        if ((rx_dataout_ready && prev_ready) || (rx_framing_error && prev_ferr)) wide_cnt++;
        if (rx_busy) busy_cycles++;
        prev_ready = rx_dataout_ready;
        prev_ferr  = rx_framing_error;
    end

    function automatic logic [7:0] got_at(input int idx);
        logic [7:0] v;
        v = 8'hxx;
        if (idx < got_q.size()) v = got_q[idx];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    task automatic test_reset();
        reset_neg = 1'b0;
        repeat (5) @(negedge clock);
        total++; if (rx_dataout !== 8'h00) $display("FAIL reset_dataout got %0h want 00", rx_dataout); else passed++;
        total++; if (rx_dataout_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", rx_dataout_ready); else passed++;
        total++; if (rx_framing_error !== 1'b0) $display("FAIL reset_ferr got %b want 0", rx_framing_error); else passed++;
        total++; if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rx_busy); else passed++;
        reset_neg = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_idle();
        int r0, f0, b0;
        r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_cycles;
        rx = 1'b1;
        #(2.0e6);
        @(negedge clock);
        total++; if (ready_cnt - r0 !== 0) $display("FAIL idle_ready got %0d want 0", ready_cnt - r0); else passed++;
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL idle_ferr got %0d want 0", ferr_cnt - f0); else passed++;
        total++; if (busy_cycles - b0 !== 0) $display("FAIL idle_busy got %0d want 0", busy_cycles - b0); else passed++;
        total++; if (rx_dataout !== 8'h00) $display("FAIL idle_dataout got %0h want 00", rx_dataout); else passed++;
    endtask

    task automatic test_frames();
        logic [7:0] bytes [4];
        int r0, f0, w0, q0;
        bytes = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        r0 = ready_cnt; f0 = ferr_cnt; w0 = wide_cnt; q0 = got_q.size();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], BIT_NS, 1'b1);
            #(BIT_NS);
        end
        @(negedge clock);
        total++; if (ready_cnt - r0 !== 4) $display("FAIL frames_count got %0d want 4", ready_cnt - r0); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_at(q0 + i) !== bytes[i]) $display("FAIL frames_byte%0d got %0h want %0h", i, got_at(q0 + i), bytes[i]);
            else passed++;
        end
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL frames_ferr got %0d want 0", ferr_cnt - f0); else passed++;
        total++; if (wide_cnt - w0 !== 0) $display("FAIL frames_pulse_width got %0d wide want 0", wide_cnt - w0); else passed++;
        last_good = bytes[3];
    endtask

    task automatic test_back_to_back(input real pct);
        logic [7:0] bytes [4];
        real bit_ns;
        int r0, f0, q0;
        bytes = '{8'hC5, 8'h3A, 8'h81, 8'h7E};
        bit_ns = 1.0e9 / (115200.0 * (1.0 + pct / 100.0));
        r0 = ready_cnt; f0 = ferr_cnt; q0 = got_q.size();
        for (int i = 0; i < 4; i++) send_byte(bytes[i], bit_ns, 1'b1);
        #(2.0 * BIT_NS);
        @(negedge clock);
        total++; if (ready_cnt - r0 !== 4) $display("FAIL b2b_count(%0.0f%%) got %0d want 4", pct, ready_cnt - r0); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_at(q0 + i) !== bytes[i]) $display("FAIL b2b_byte%0d(%0.0f%%) got %0h want %0h", i, pct, got_at(q0 + i), bytes[i]);
            else passed++;
        end
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL b2b_ferr(%0.0f%%) got %0d want 0", pct, ferr_cnt - f0); else passed++;
        last_good = bytes[3];
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = ready_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        #(2000.0);
        @(negedge clock);
        total++; if (rx_busy !== 1'b1) $display("FAIL glitch_seen got busy=%b want 1", rx_busy); else passed++;
        rx = 1'b1;
        #(2.0 * BIT_NS);
        @(negedge clock);
        total++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle got busy=%b want 0", rx_busy); else passed++;
        total++; if (ready_cnt - r0 !== 0) $display("FAIL glitch_ready got %0d want 0", ready_cnt - r0); else passed++;
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_ferr got %0d want 0", ferr_cnt - f0); else passed++;
        total++; if (rx_dataout !== last_good) $display("FAIL glitch_dataout got %0h want %0h", rx_dataout, last_good); else passed++;
    endtask

    task automatic test_break();
        int r0, f0, b0, w0, q0;
        r0 = ready_cnt; f0 = ferr_cnt; b0 = both_cnt; w0 = wide_cnt;
        send_byte(8'h3C, BIT_NS, 1'b0);
        #(19.0 * BIT_NS);
        @(negedge clock);
        total++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr_once got %0d want 1", ferr_cnt - f0); else passed++;
        total++; if (ready_cnt - r0 !== 0) $display("FAIL break_no_ready got %0d want 0", ready_cnt - r0); else passed++;
        total++; if (rx_dataout !== last_good) $display("FAIL break_dataout_hold got %0h want %0h", rx_dataout, last_good); else passed++;
        total++; if (rx_busy !== 1'b1) $display("FAIL break_busy got %b want 1", rx_busy); else passed++;
        rx = 1'b1;
        #(2.0 * BIT_NS);
        @(negedge clock);
        total++; if (rx_busy !== 1'b0) $display("FAIL break_exit got busy=%b want 0", rx_busy); else passed++;
        q0 = got_q.size();
        send_byte(8'h7E, BIT_NS, 1'b1);
        #(BIT_NS);
        @(negedge clock);
        total++; if (ready_cnt - r0 !== 1) $display("FAIL break_recover_count got %0d want 1", ready_cnt - r0); else passed++;
        total++; if (got_at(q0) !== 8'h7E) $display("FAIL break_recover_byte got %0h want 7e", got_at(q0)); else passed++;
        total++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr_total got %0d want 1", ferr_cnt - f0); else passed++;
        total++; if (both_cnt - b0 !== 0) $display("FAIL break_strobe_overlap got %0d want 0", both_cnt - b0); else passed++;
        total++; if (wide_cnt - w0 !== 0) $display("FAIL break_pulse_width got %0d wide want 0", wide_cnt - w0); else passed++;
        last_good = 8'h7E;
    endtask

    task automatic test_abort(input logic use_reset);
        logic [7:0] b;
        int r0, f0, q0;
        b = 8'h96;
        r0 = ready_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = b[4];
        #(BIT_NS / 2.0);
        @(negedge clock);
        total++; if (rx_busy !== 1'b1) $display("FAIL abort%0d_midframe got busy=%b want 1", use_reset, rx_busy); else passed++;
        if (use_reset) reset_neg = 1'b0; else ppc = 1'b1;
        @(negedge clock);
        total++; if (rx_dataout !== 8'h00) $display("FAIL abort%0d_dataout got %0h want 00", use_reset, rx_dataout); else passed++;
        total++; if (rx_busy !== 1'b0) $display("FAIL abort%0d_busy got %b want 0", use_reset, rx_busy); else passed++;
        total++; if (rx_dataout_ready !== 1'b0 || rx_framing_error !== 1'b0)
            $display("FAIL abort%0d_strobes got %b%b want 00", use_reset, rx_dataout_ready, rx_framing_error); else passed++;
        reset_neg = 1'b1;
        ppc = 1'b0;
        rx = 1'b1;
        #(2.0 * BIT_NS);
        q0 = got_q.size();
        total++; if (ready_cnt - r0 !== 0) $display("FAIL abort%0d_no_ready got %0d want 0", use_reset, ready_cnt - r0); else passed++;
        send_byte(8'h69, BIT_NS, 1'b1);
        #(BIT_NS);
        @(negedge clock);
        total++; if (ready_cnt - r0 !== 1) $display("FAIL abort%0d_next_count got %0d want 1", use_reset, ready_cnt - r0); else passed++;
        total++; if (got_at(q0) !== 8'h69) $display("FAIL abort%0d_next_byte got %0h want 69", use_reset, got_at(q0)); else passed++;
        total++; if (ferr_cnt - f0 !== 0) $display("FAIL abort%0d_ferr got %0d want 0", use_reset, ferr_cnt - f0); else passed++;
        last_good = 8'h69;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frames();
        test_back_to_back(3.0);
        test_back_to_back(-3.0);
        test_glitch();
        test_break();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
